mul_unit_seq: RTL and testbench

//   Iterative shift-add multiplier in the EX stage, beside the 32-bit ALU built from the 1-bit ALU slices.

---
 rtl/mul_unit_seq_if.sv | 32 +++
 rtl/mul_unit_seq.sv | 135 +++++++++++++
 tb/tb_mul_unit_seq.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_unit_seq_if                                               |
// | Purpose  : Request/response bundle between the EX stage (master) and     |
// |            the iterative multiplier (slave).                             |
// | Signals  : Start, SignedOp, DataA, DataB  master -> slave (request)      |
// |            Busy, Done, Hi, Lo             slave -> master (status/result)|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface mul_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             SignedOp;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, SignedOp, DataA, DataB,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, SignedOp, DataA, DataB,
    output Busy, Done, Hi, Lo
  );
endinterface
`default_nettype wire

// File: rtl/mul_unit_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_unit_seq                                                  |
// | Purpose  : Iterative shift-add MULT/MULTU unit for the EX stage. One     |
// |            partial-product step per clock, WIDTH steps per operation;    |
// |            the 2*WIDTH-bit product lands in the HI/LO registers.         |
// | Ports    : clk  - clock, rising edge                                     |
// |            rst  - asynchronous active-high reset                         |
// |            bus  - mul_unit_seq_if.slave                                  |
// |                   Start/SignedOp/DataA/DataB in, Busy/Done/Hi/Lo out     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mul_unit_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_unit_seq_if.slave bus
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_busy;
  logic               w_done;

  logic [WIDTH-1:0]   r_mag_a;
  logic               r_neg;
  // Product/multiplier shift register. The architectural register carries
  // one extra top bit, but that bit is always zero once the shift has
  // consumed the carry, so it is not stored.
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_load;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_p_next;
  logic [2*WIDTH-1:0] w_result;

  // A request is only honoured outside RUN; during RUN it is dropped.
  assign w_load = bus.Start && (r_state != RUN);
  assign w_last = (r_cnt == c_last);

  // Magnitudes: negating the most negative value yields 2^(WIDTH-1), which
  // is still correct when read as an unsigned WIDTH-bit magnitude.
  assign w_mag_a = (bus.SignedOp && bus.DataA[WIDTH-1]) ? -bus.DataA : bus.DataA;
  assign w_mag_b = (bus.SignedOp && bus.DataB[WIDTH-1]) ? -bus.DataB : bus.DataB;
  assign w_neg   = bus.SignedOp && (bus.DataA[WIDTH-1] ^ bus.DataB[WIDTH-1]);

  // One shift-add step: conditional add into the upper half keeping the
  // carry, then shift right with that carry entering at the top.
  assign w_addend = r_p[0] ? r_mag_a : '0;
  assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_p_next = {w_sum, r_p[WIDTH-1:1]};
  assign w_result = r_neg ? -w_p_next : w_p_next;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) w_state_next = RUN;
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = bus.Start ? RUN : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_neg   <= 1'b0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_load) begin
      r_mag_a <= w_mag_a;
      r_neg   <= w_neg;
      r_p     <= {{WIDTH{1'b0}}, w_mag_b};
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + c_cnt_one;
      // HI/LO only ever see the finished, sign-corrected product.
      if (w_last) begin
        r_hi <= w_result[2*WIDTH-1:WIDTH];
        r_lo <= w_result[WIDTH-1:0];
      end
    end
  end

  assign bus.Busy = w_busy;
  assign bus.Done = w_done;
  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_unit_seq                                               |
// | Purpose  : Self-checking bench for mul_unit_seq: directed corner cases,  |
// |            ignored Start during RUN, back-to-back, mid-run reset and     |
// |            random operations against an arithmetic reference.           |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mul_unit_seq;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mul_unit_seq_if #(.WIDTH(32)) bus ();

  mul_unit_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.Start    = 1'b1;
    bus.SignedOp = s;
    bus.DataA    = a;
    bus.DataB    = b;
    tick();
    bus.Start    = 1'b0;
  endtask

  // Counts sampled Busy cycles until Done; a missing Done is a failed check.
  task automatic wait_done(input string tag, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 40 && bus.Done !== 1'b1; i++) begin
      if (bus.Busy === 1'b1) nbusy++;
      tick();
    end
    chk({tag, "_done"}, {63'd0, bus.Done}, 64'd1);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input string tag);
    int nb;
    start_op(a, b, s);
    wait_done(tag, nb);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd32);
    chk({tag, "_hilo"}, {bus.Hi, bus.Lo}, ref_mul(a, b, s));
    tick();
    chk({tag, "_done_pulse"}, {63'd0, bus.Done}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nb;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] held;

    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    bus.Start    = 1'b0;
    bus.SignedOp = 1'b0;
    bus.DataA    = '0;
    bus.DataB    = '0;

    // Reset pulse then three idle cycles.
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Done}, 64'd0);

    // Directed corner cases (expected values also written out literally).
    do_op(32'd3, 32'd5, 1'b0, "multu_3x5");
    chk("multu_3x5_const", {bus.Hi, bus.Lo}, 64'h0000_0000_0000_000F);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    chk("multu_max_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(-32'sd7, 32'd3, 1'b1, "mult_m7x3");
    chk("mult_m7x3_const", {bus.Hi, bus.Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, "mult_min");
    chk("mult_min_const", {bus.Hi, bus.Lo}, 64'h4000_0000_0000_0000);

    // Hi/Lo hold while idle.
    held = {bus.Hi, bus.Lo};
    repeat (3) tick();
    chk("hold_idle", {bus.Hi, bus.Lo}, held);

    // Start during RUN is ignored.
    start_op(32'd6, 32'd7, 1'b0);
    repeat (4) tick();
    start_op(32'd2, 32'd2, 1'b0);
    chk("ign_hilo_unchanged", {bus.Hi, bus.Lo}, held);
    wait_done("ign", nb);
    chk("ign_busy_cycles", 64'(nb), 64'd27);
    chk("ign_hilo", {bus.Hi, bus.Lo}, 64'd42);
    tick();
    chk("ign_no_restart", {63'd0, bus.Busy}, 64'd0);

    // Back-to-back: Start presented while Done is high.
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_done("b2b_first", nb);
    chk("b2b_first_hilo", {bus.Hi, bus.Lo}, ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0));
    start_op(-32'sd100, 32'd12345, 1'b1);
    chk("b2b_busy_after_load", {63'd0, bus.Busy}, 64'd1);
    wait_done("b2b_second", nb);
    chk("b2b_second_busy_cycles", 64'(nb), 64'd32);
    chk("b2b_second_hilo", {bus.Hi, bus.Lo}, ref_mul(-32'sd100, 32'd12345, 1'b1));
    tick();

    // Asynchronous reset in the middle of a run.
    start_op(32'd9, 32'd9, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.Done}, 64'd0);
    chk("midrst_hilo", {bus.Hi, bus.Lo}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_idle", {63'd0, bus.Busy}, 64'd0);
    do_op(32'd2, 32'd3, 1'b0, "after_rst");

    // Random operations, occasionally chained back-to-back.
    for (int n = 0; n < 16; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      rs = 1'($urandom_range(0, 1));
      start_op(ra, rb, rs);
      wait_done("rand", nb);
      chk("rand_busy_cycles", 64'(nb), 64'd32);
      chk("rand_hilo", {bus.Hi, bus.Lo}, ref_mul(ra, rb, rs));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        held = {bus.Hi, bus.Lo};
        repeat (2) tick();
        chk("rand_hold", {bus.Hi, bus.Lo}, held);
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
